median_window_sched: RTL and testbench

Controller that turns a raster pixel stream into serial 3x3 windows for the shared 9-input median engine and collects its results. It holds two line buffers and a 3x3 window register. For every interior pixel it feeds 9 samples to the engine, waits for the engine's done strobe, and emits one filtered pixel. It sits between the video input pipeline and the median engine and provides valid-only filtering: the output frame is (H-2) x (LINE-2).

---
 rtl/median_window_sched.sv | 168 ++++++++++++++++
 tb/tb_median_window_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_sched.sv
// Raster-to-window scheduler for the shared 9-input median engine: two line
// buffers feed a 3x3 window that is streamed serially, and one result is emitted per interior pixel.
module median_window_sched #(
  parameter int W    = 8,
  parameter int LINE = 640,
  parameter int TMO  = 255
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [W-1:0] PIX_I,
  input  logic         PIX_VALID_I,
  input  logic         SOF_I,
  output logic         PIX_READY_O,
  output logic [W-1:0] MED_DI_O,
  output logic         MED_DSI_O,
  input  logic [W-1:0] MED_DO_I,
  input  logic         MED_DSO_I,
  output logic [W-1:0] PIX_O,
  output logic         PIX_VALID_O,
  output logic         EOL_O,
  output logic         ERR_O
);

  // state | meaning
  // IDLE  | ready for a pixel; accept registers it and reads both line buffers
  // FETCH | shift window, load new column, update line buffers and counters
  // FEED  | stream the 9 window samples to the engine
  // WAIT  | wait for the engine result or the timeout
  // EMIT  | one-cycle output pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;

  localparam int AW = $clog2(LINE);
  localparam int TW = $clog2(TMO + 1);

  logic [2:0]    state;
  logic [AW-1:0] col;
  logic [1:0]    row;
  logic [3:0]    k;
  logic [TW-1:0] tcnt;
  logic [W-1:0]  pix_r;
  logic          eol;
  logic [W-1:0]  rd0;
  logic [W-1:0]  rd1;
  logic [W-1:0]  buf0 [LINE];
  logic [W-1:0]  buf1 [LINE];
  logic [W-1:0]  win  [3][3];
  logic [W-1:0]  feed_val;
  logic          accept;
  logic [AW-1:0] col_eff;
  logic [1:0]    row_eff;

  assign PIX_READY_O = (state == S_IDLE) & nRST;
  assign accept      = PIX_VALID_I & PIX_READY_O;
  assign col_eff     = SOF_I ? '0 : col;
  assign row_eff     = SOF_I ? 2'd0 : row;

  assign MED_DSI_O   = (state == S_FEED);
  assign MED_DI_O    = MED_DSI_O ? feed_val : '0;
  assign PIX_VALID_O = (state == S_EMIT);
  assign EOL_O       = PIX_VALID_O & eol;

  always_comb begin
    feed_val = '0;
    case (k)
      4'd0: feed_val = win[0][0];
      4'd1: feed_val = win[0][1];
      4'd2: feed_val = win[0][2];
      4'd3: feed_val = win[1][0];
      4'd4: feed_val = win[1][1];
      4'd5: feed_val = win[1][2];
      4'd6: feed_val = win[2][0];
      4'd7: feed_val = win[2][1];
      4'd8: feed_val = win[2][2];
      default: feed_val = '0;
    endcase
  end

  // Line buffers are never cleared; row/col gating masks stale contents.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && accept) begin
      rd0 <= buf0[col_eff];
      rd1 <= buf1[col_eff];
    end
    if (state == S_FETCH) begin
      buf1[col] <= rd0;
      buf0[col] <= pix_r;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= 2'd0;
      k     <= 4'd0;
      tcnt  <= '0;
      pix_r <= '0;
      eol   <= 1'b0;
      PIX_O <= '0;
      ERR_O <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pix_r <= PIX_I;
            col   <= col_eff;
            row   <= row_eff;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
          end
          win[0][2] <= rd1;
          win[1][2] <= rd0;
          win[2][2] <= pix_r;
          if (col == AW'(LINE - 1)) begin
            col <= '0;
            row <= (row == 2'd2) ? 2'd2 : row + 2'd1;
          end else begin
            col <= col + AW'(1);
          end
          if (row == 2'd2 && col >= AW'(2)) begin
            eol   <= (col == AW'(LINE - 1));
            k     <= 4'd0;
            state <= S_FEED;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FEED: begin
          if (k == 4'd8) begin
            k     <= 4'd0;
            tcnt  <= TW'(TMO - 1);
            state <= S_WAIT;
          end else begin
            k <= k + 4'd1;
          end
        end
        S_WAIT: begin
          // A result arriving on the timeout cycle takes priority over the pass-through.
          if (MED_DSO_I) begin
            PIX_O <= MED_DO_I;
            state <= S_EMIT;
          end else if (tcnt == '0) begin
            PIX_O <= win[1][1];
            ERR_O <= 1'b1;
            state <= S_EMIT;
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        S_EMIT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_sched.sv
// Scoreboard bench for median_window_sched: a behavioural median engine with
// per-window latency, expected outputs queued at pixel acceptance.
module tb_median_window_sched;
  localparam int W    = 8;
  localparam int LINE = 4;
  localparam int TMO  = 16;
  localparam int MUTE = TMO + 100;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [W-1:0] PIX_I = '0;
  logic         PIX_VALID_I = 1'b0;
  logic         SOF_I = 1'b0;
  logic         PIX_READY_O;
  logic [W-1:0] MED_DI_O;
  logic         MED_DSI_O;
  logic [W-1:0] MED_DO_I;
  logic         MED_DSO_I;
  logic [W-1:0] PIX_O;
  logic         PIX_VALID_O;
  logic         EOL_O;
  logic         ERR_O;

  median_window_sched #(.W(W), .LINE(LINE), .TMO(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_I(PIX_I), .PIX_VALID_I(PIX_VALID_I), .SOF_I(SOF_I),
    .PIX_READY_O(PIX_READY_O), .MED_DI_O(MED_DI_O), .MED_DSI_O(MED_DSI_O),
    .MED_DO_I(MED_DO_I), .MED_DSO_I(MED_DSO_I), .PIX_O(PIX_O), .PIX_VALID_O(PIX_VALID_O),
    .EOL_O(EOL_O), .ERR_O(ERR_O)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] pix;
    logic         eol;
    int           cyc;
  } exp_t;

  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           n_out = 0;
  exp_t         exp_q[$];
  int           lat_q[$];
  logic [W-1:0] samp_q[$];
  logic [W-1:0] img [0:7][0:LINE-1];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [W-1:0] med9(input logic [W-1:0] v [9]);
    logic [W-1:0] a [9];
    logic [W-1:0] t;
    a = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  function automatic logic [W-1:0] med_at(input int r, input int c);
    logic [W-1:0] v [9];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[i*3+j] = img[r-2+i][c-2+j];
    return med9(v);
  endfunction

  // Behavioural engine: collects a strobe run, answers after the queued latency.
  initial begin
    int           nsamp;
    int           wl;
    bit           pend;
    logic [W-1:0] s [9];
    logic [W-1:0] mres;
    MED_DSO_I = 1'b0;
    MED_DO_I  = '0;
    nsamp = 0; wl = 0; pend = 0; mres = '0;
    for (int i = 0; i < 9; i++) s[i] = '0;
    forever begin
      @(negedge CLK);
      MED_DSO_I = 1'b0;
      if (!nRST) begin
        nsamp = 0;
        pend  = 0;
      end else if (MED_DSI_O) begin
        if (nsamp < 9) s[nsamp] = MED_DI_O;
        nsamp++;
        samp_q.push_back(MED_DI_O);
      end else begin
        if (nsamp != 0) begin
          n_checks++;
          if (nsamp != 9) $display("FAIL dsi_run: got %0d strobes, want 9", nsamp);
          else n_pass++;
          mres  = med9(s);
          nsamp = 0;
          if (lat_q.size() == 0) begin
            n_checks++;
            $display("FAIL engine_lat: window with no queued latency, want one");
            pend = 0;
          end else begin
            wl   = lat_q.pop_front() - 1;
            pend = (wl < TMO);
          end
        end else if (pend) begin
          wl--;
        end
        if (pend && wl == 0) begin
          MED_DSO_I = 1'b1;
          MED_DO_I  = mres;
          pend      = 0;
        end
      end
    end
  end

  // Output monitor / scoreboard pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (PIX_VALID_O === 1'b1) begin
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL stray_out: got PIX_O=%0d at cycle %0d, want no output", PIX_O, cyc);
        end else begin
          e = exp_q.pop_front();
          if (PIX_O !== e.pix || EOL_O !== e.eol || cyc != e.cyc)
            $display("FAIL out: got pix=%0d eol=%0b cyc=%0d, want pix=%0d eol=%0b cyc=%0d",
                     PIX_O, EOL_O, cyc, e.pix, e.eol, e.cyc);
          else n_pass++;
        end
      end
    end
  end

  // Drives one pixel from a negedge; returns at the negedge after acceptance.
  task automatic send_px(input int r, input int c, input bit sof, input int lat, output int acc);
    int   t;
    exp_t e;
    PIX_I = img[r][c];
    SOF_I = sof;
    PIX_VALID_I = 1'b1;
    t = 0;
    while (PIX_READY_O !== 1'b1 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) begin
      n_checks++;
      $display("FAIL accept_timeout: pixel r%0d c%0d not accepted in 300 cycles", r, c);
      acc = -1;
    end else begin
      acc = cyc;
      if (r >= 2 && c >= 2) begin
        lat_q.push_back(lat);
        e.pix = (lat > TMO) ? img[r-1][c-1] : med_at(r, c);
        e.eol = (c == LINE - 1);
        e.cyc = acc + 11 + ((lat > TMO) ? TMO : lat);
        exp_q.push_back(e);
      end
    end
    @(negedge CLK);
  endtask

  task automatic send_frame(input int rows, input int lat_fix);
    int acc;
    int prev;
    bit prev_int;
    prev = 0; prev_int = 1;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LINE; c++) begin
        send_px(r, c, (r == 0 && c == 0), (lat_fix > 0) ? lat_fix : $urandom_range(1, TMO), acc);
        if (!prev_int) begin
          n_checks++;
          if (acc - prev != 2) $display("FAIL back_to_back: accept gap %0d, want 2", acc - prev);
          else n_pass++;
        end
        prev = acc;
        prev_int = (r >= 2 && c >= 2);
      end
    PIX_VALID_I = 1'b0;
    SOF_I = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    PIX_VALID_I = 1'b1;
    PIX_I = 8'hAA;
    SOF_I = 1'b1;
    repeat (5) @(negedge CLK);
    n_checks++;
    if ({PIX_O, PIX_VALID_O, EOL_O, ERR_O, MED_DSI_O, MED_DI_O, PIX_READY_O} !== '0)
      $display("FAIL reset_outs: got pix=%0d v=%0b eol=%0b err=%0b dsi=%0b di=%0d rdy=%0b, want all 0",
               PIX_O, PIX_VALID_O, EOL_O, ERR_O, MED_DSI_O, MED_DI_O, PIX_READY_O);
    else n_pass++;
    nRST = 1'b1;
    PIX_VALID_I = 1'b0;
    SOF_I = 1'b0;
    #1;
    n_checks++;
    if (PIX_READY_O !== 1'b1) $display("FAIL reset_ready: got %0b after release, want 1", PIX_READY_O);
    else n_pass++;
    @(negedge CLK);
  endtask

  task automatic test_all7();
    int o0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < LINE; c++) img[r][c] = 8'd7;
    o0 = n_out;
    send_frame(4, 3);
    drain();
    n_checks++;
    if (n_out - o0 != 4 || exp_q.size() != 0)
      $display("FAIL all7_count: got %0d outputs (%0d pending), want 4", n_out - o0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_feed_order();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) img[r][c] = 8'(r * 3 + c + 1);
      img[r][3] = 8'(10 + r);
    end
    samp_q.delete();
    send_frame(3, 1);
    drain();
    n_checks++;
    if (samp_q.size() != 18) $display("FAIL feed_len: got %0d samples, want 18", samp_q.size());
    else n_pass++;
    for (int i = 0; i < 9 && i < samp_q.size(); i++) begin
      n_checks++;
      if (samp_q[i] !== 8'(i + 1)) $display("FAIL feed_seq[%0d]: got %0d, want %0d", i, samp_q[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int acc;
    int o0;
    // Partial frame first so the real frame's SOF lands mid-line.
    for (int c = 0; c < LINE; c++) img[0][c] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) send_px(0, i % LINE, (i == 0), 1, acc);
    for (int r = 0; r < 8; r++) for (int c = 0; c < LINE; c++) img[r][c] = 8'($urandom_range(0, 255));
    o0 = n_out;
    send_frame(8, 0);
    drain();
    n_checks++;
    if (n_out - o0 != 6 * (LINE - 2) || exp_q.size() != 0)
      $display("FAIL random_count: got %0d outputs, want %0d", n_out - o0, 6 * (LINE - 2));
    else n_pass++;
    n_checks++;
    if (ERR_O !== 1'b0) $display("FAIL random_err: got ERR_O=%0b, want 0", ERR_O);
    else n_pass++;
  endtask

  task automatic test_timeout();
    for (int r = 0; r < 3; r++) for (int c = 0; c < LINE; c++) img[r][c] = 8'(40 + r * 10 + c);
    send_frame(3, MUTE);
    drain();
    n_checks++;
    if (ERR_O !== 1'b1 || exp_q.size() != 0)
      $display("FAIL timeout_err: got ERR_O=%0b pending=%0d, want 1 and 0", ERR_O, exp_q.size());
    else n_pass++;
    repeat (10) @(negedge CLK);
    n_checks++;
    if (ERR_O !== 1'b1) $display("FAIL err_sticky: got ERR_O=%0b, want 1", ERR_O);
    else n_pass++;
  endtask

  task automatic test_reset_wait();
    int acc;
    int t;
    int o0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < LINE; c++) img[r][c] = 8'(100 + r * 4 + c);
    for (int i = 0; i < 2 * LINE + 3; i++) send_px(i / LINE, i % LINE, (i == 0), MUTE, acc);
    PIX_VALID_I = 1'b0;
    SOF_I = 1'b0;
    t = 0;
    while (MED_DSI_O !== 1'b1 && t < 50) begin @(negedge CLK); t++; end
    while (MED_DSI_O === 1'b1 && t < 50) begin @(negedge CLK); t++; end
    n_checks++;
    if (t >= 50) $display("FAIL wait_entry: no strobe run within 50 cycles");
    else n_pass++;
    repeat (2) @(negedge CLK);
    nRST = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    n_checks++;
    if (PIX_VALID_O !== 1'b0 || ERR_O !== 1'b0 || MED_DSI_O !== 1'b0)
      $display("FAIL rst_wait: got v=%0b err=%0b dsi=%0b, want 0 0 0", PIX_VALID_O, ERR_O, MED_DSI_O);
    else n_pass++;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    for (int r = 0; r < 4; r++) for (int c = 0; c < LINE; c++) img[r][c] = 8'($urandom_range(0, 255));
    o0 = n_out;
    send_frame(4, 2);
    drain();
    n_checks++;
    if (n_out - o0 != 4 || exp_q.size() != 0)
      $display("FAIL post_rst_count: got %0d outputs, want 4", n_out - o0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_all7();
    test_feed_order();
    test_random();
    test_timeout();
    test_reset_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
